// File: rtl/pc_sequencer.sv
// Fetch/decode/issue controller for program_counter: fetches over a req/ack port,
// resolves branches and jumps against the status flags, and waits for the execute unit.
module pc_sequencer #(
   parameter int AW = 32,
   parameter int IW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] pc_out,
   input  logic [3:0]    status,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_ack,
   input  logic [IW-1:0] imem_rdata,
   output logic          exec_valid,
   output logic [IW-1:0] exec_instr,
   input  logic          exec_done,
   output logic [1:0]    ps,
   output logic [AW-1:0] pc_in,
   output logic          halt,
   output logic [31:0]   instr_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_UPDATE,
      S_HALT
   } state_t;

   localparam logic [1:0] PS_HOLD   = 2'b00;
   localparam logic [1:0] PS_INC    = 2'b01;
   localparam logic [1:0] PS_LOAD   = 2'b10;
   localparam logic [1:0] PS_OFFSET = 2'b11;

   state_t        state_reg, state_next;
   logic [IW-1:0] ir_reg;
   logic [1:0]    ps_next_reg;
   logic [AW-1:0] pc_in_reg;
   logic [31:0]   count_reg;

   logic [3:0]    opcode;
   logic [3:0]    cond;
   logic [AW-1:0] branch_offset;
   logic [AW-1:0] jump_target;
   logic          cond_taken;
   logic          flag_n, flag_z, flag_c, flag_v;

   assign opcode        = ir_reg[IW-1 -: 4];
   assign cond          = ir_reg[27:24];
   assign branch_offset = {{(AW-24){ir_reg[23]}}, ir_reg[23:0]};
   assign jump_target   = {{(AW-24){1'b0}}, ir_reg[23:0]};
   assign {flag_n, flag_z, flag_c, flag_v} = status;

   always_comb begin
      cond_taken = 1'b0;
      case (cond)
         4'h0:    cond_taken = 1'b1;
         4'h1:    cond_taken = flag_z;
         4'h2:    cond_taken = !flag_z;
         4'h3:    cond_taken = flag_c;
         4'h4:    cond_taken = !flag_c;
         4'h5:    cond_taken = flag_n;
         4'h6:    cond_taken = !flag_n;
         4'h7:    cond_taken = flag_v;
         4'h8:    cond_taken = !flag_v;
         4'h9:    cond_taken = (flag_n == flag_v);
         4'hA:    cond_taken = (flag_n != flag_v);
         4'hB:    cond_taken = !flag_z && (flag_n == flag_v);
         4'hC:    cond_taken = flag_z || (flag_n != flag_v);
         default: cond_taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:   state_next = S_FETCH;
         S_FETCH:  if (imem_ack) state_next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               4'hA, 4'hB: state_next = S_UPDATE;
               4'hF:       state_next = S_HALT;
               default:    state_next = S_EXEC;
            endcase
         end
         S_EXEC:   if (exec_done) state_next = S_UPDATE;
         S_UPDATE: state_next = S_FETCH;
         S_HALT:   state_next = S_HALT;
         default:  state_next = S_IDLE;
      endcase
   end

   // IR, the pending PC command and the retire counter; pc_in only changes on taken redirects.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ir_reg      <= '0;
         ps_next_reg <= PS_HOLD;
         pc_in_reg   <= '0;
         count_reg   <= '0;
      end else begin
         case (state_reg)
            S_FETCH: begin
               if (imem_ack) ir_reg <= imem_rdata;
            end
            S_DECODE: begin
               case (opcode)
                  4'hA: begin
                     if (cond_taken) begin
                        ps_next_reg <= PS_OFFSET;
                        pc_in_reg   <= branch_offset;
                     end else begin
                        ps_next_reg <= PS_INC;
                     end
                  end
                  4'hB: begin
                     ps_next_reg <= PS_LOAD;
                     pc_in_reg   <= jump_target;
                  end
                  default: ps_next_reg <= PS_INC;
               endcase
            end
            S_UPDATE: count_reg <= count_reg + 32'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      imem_req   = (state_reg == S_FETCH);
      exec_valid = (state_reg == S_EXEC);
      halt       = (state_reg == S_HALT);
      ps         = (state_reg == S_UPDATE) ? ps_next_reg : PS_HOLD;
   end

   // The PC is frozen (ps=00) throughout FETCH, so the address follows the register directly.
   assign imem_addr   = pc_out;
   assign exec_instr  = ir_reg;
   assign pc_in       = pc_in_reg;
   assign instr_count = count_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: instruction memory, execute unit and
// program counter are modelled here; retired instructions are checked via a scoreboard.
module tb_pc_sequencer;

   logic        clk;
   logic        rst;
   logic [31:0] pc_out;
   logic [3:0]  status;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        exec_valid;
   logic [31:0] exec_instr;
   logic        exec_done;
   logic [1:0]  ps;
   logic [31:0] pc_in;
   logic        halt;
   logic [31:0] instr_count;

   pc_sequencer #(.AW(32), .IW(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .pc_out     (pc_out),
      .status     (status),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .exec_valid (exec_valid),
      .exec_instr (exec_instr),
      .exec_done  (exec_done),
      .ps         (ps),
      .pc_in      (pc_in),
      .halt       (halt),
      .instr_count(instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  ps;
      logic [31:0] pc_in;
      logic [31:0] cnt;
      logic [31:0] instr;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] pc_model = 32'd7;
   logic [31:0] model_count = 0;
   logic [31:0] cur_instr = 0;
   int          n_retired = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Architectural meaning of each condition code on flags {N,Z,C,V}.
   function automatic bit ref_taken(input logic [3:0] c, input logic [3:0] st);
      bit n, z, cf, v;
      n = st[3]; z = st[2]; cf = st[1]; v = st[0];
      case (c)
         4'd0:  return 1'b1;
         4'd1:  return z;
         4'd2:  return !z;
         4'd3:  return cf;
         4'd4:  return !cf;
         4'd5:  return n;
         4'd6:  return !n;
         4'd7:  return v;
         4'd8:  return !v;
         4'd9:  return n == v;
         4'd10: return n != v;
         4'd11: return !z && (n == v);
         4'd12: return z || (n != v);
         default: return 1'b0;
      endcase
   endfunction

   function automatic exp_t ref_model(input logic [31:0] instr, input logic [3:0] st);
      exp_t e;
      logic [31:0] field;
      field   = instr & 32'h00FF_FFFF;
      e.instr = instr;
      e.pc_in = 32'd0;
      e.cnt   = 32'd0;
      if (instr[31:28] == 4'hA) begin
         if (ref_taken(instr[27:24], st)) begin
            e.ps    = 2'd3;
            e.pc_in = (field >= 32'h0080_0000) ? field - 32'h0100_0000 : field;
         end else begin
            e.ps = 2'd1;
         end
      end else if (instr[31:28] == 4'hB) begin
         e.ps    = 2'd2;
         e.pc_in = field;
      end else begin
         e.ps = 2'd1;
      end
      return e;
   endfunction

   // Monitor: compares every UPDATE cycle against the scoreboard and advances the PC model.
   logic [31:0] cnt_exp;
   bit          cnt_pend = 0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            cnt_pend = 0;
         end else begin
            if (cnt_pend) begin
               chk("instr_count", instr_count, cnt_exp);
               cnt_pend = 0;
            end
            if (imem_req) chk("imem_addr", imem_addr, pc_model);
            if (exec_valid) chk("exec_instr", exec_instr, cur_instr);
            if (ps != 2'b00) begin
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_update: got ps=%0d expected no update", ps);
               end else begin
                  e = sb.pop_front();
                  chk("ps", {30'd0, ps}, {30'd0, e.ps});
                  if (e.ps[1]) chk("pc_in", pc_in, e.pc_in);
                  n_retired++;
                  $display("update %0d instr=%h ps=%0d pc_in=%h pc=%h", n_retired, e.instr, ps, pc_in, pc_model);
                  cnt_exp  = e.cnt;
                  cnt_pend = 1;
                  case (e.ps)
                     2'd1:    pc_model = pc_model + 32'd1;
                     2'd2:    pc_model = e.pc_in;
                     2'd3:    pc_model = pc_model + e.pc_in;
                     default: ;
                  endcase
                  pc_out = pc_model;
               end
            end
         end
      end
   end

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (imem_req) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         n_cmp++;
         n_err++;
         $display("FAIL req_timeout: got imem_req=0 expected 1 within 50 cycles");
      end
   endtask

   task automatic do_instr(input logic [31:0] instr, input logic [3:0] st,
                           input int ack_dly, input int done_dly, input bit stray);
      bit   ok;
      exp_t e;
      wait_req(ok);
      if (!ok) return;
      status = st;
      repeat (ack_dly) @(negedge clk);
      e = ref_model(instr, st);
      model_count = model_count + 32'd1;
      e.cnt = model_count;
      sb.push_back(e);
      cur_instr  = instr;
      imem_rdata = instr;
      imem_ack   = 1'b1;
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      if (instr[31:28] == 4'hA || instr[31:28] == 4'hB) begin
         chk("branch_latency", {30'd0, ps}, {30'd0, e.ps});
      end else begin
         chk("exec_latency", {31'd0, exec_valid}, 32'd1);
         if (stray && done_dly > 0) begin
            imem_ack   = 1'b1;
            imem_rdata = $urandom;
         end
         for (int i = 0; i < done_dly; i++) begin
            @(negedge clk);
            imem_ack = 1'b0;
            chk("exec_hold", {31'd0, exec_valid}, 32'd1);
         end
         exec_done = 1'b1;
         @(negedge clk);
         exec_done = 1'b0;
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [3:0]  op;
      logic [31:0] r;
      op = 4'($urandom_range(0, 14));
      if ($urandom_range(0, 2) == 0) op = 4'hA;
      r = $urandom;
      return {op, r[27:0]};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish before timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ok;
      rst        = 1'b0;
      pc_out     = 32'd7;
      status     = 4'd0;
      imem_ack   = 1'b0;
      imem_rdata = 32'd0;
      exec_done  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ps", {30'd0, ps}, 32'd0);
      chk("rst_pc_in", pc_in, 32'd0);
      chk("rst_ir", exec_instr, 32'd0);
      chk("rst_count", instr_count, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_exec_valid", {31'd0, exec_valid}, 32'd0);
      chk("rst_halt", {31'd0, halt}, 32'd0);
      rst = 1'b1;
      #1 chk("idle_req", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
      chk("first_fetch_req", {31'd0, imem_req}, 32'd1);
      chk("first_fetch_addr", imem_addr, 32'd7);

      do_instr(32'h1234_5678, 4'b0000, 0, 2, 0);
      do_instr(32'hA1FF_FFFE, 4'b0100, 0, 0, 0);
      do_instr(32'hA1FF_FFFE, 4'b0000, 1, 0, 0);
      do_instr(32'hAB00_0004, 4'b0000, 0, 0, 0);
      do_instr(32'hAB00_0004, 4'b1000, 0, 0, 0);
      for (int s = 0; s < 16; s++) do_instr(32'hAD00_0004, 4'(s), 0, 0, 0);
      do_instr(32'hB000_0040, 4'b0000, 3, 0, 0);
      do_instr(32'h5555_AAAA, 4'b0000, 0, 3, 1);

      for (int i = 0; i < 150; i++) begin
         int dd;
         dd = $urandom_range(0, 3);
         do_instr(rand_instr(), 4'($urandom), $urandom_range(0, 3), dd,
                  (dd > 0) && ($urandom_range(0, 3) == 0));
      end

      // Asynchronous reset while an instruction sits in EXEC.
      wait_req(ok);
      if (ok) begin
         cur_instr  = 32'h3000_0001;
         imem_rdata = cur_instr;
         imem_ack   = 1'b1;
         @(negedge clk);
         imem_ack = 1'b0;
         @(negedge clk);
         chk("pre_reset_exec", {31'd0, exec_valid}, 32'd1);
         #2 rst = 1'b0;
         #1;
         chk("async_exec_valid", {31'd0, exec_valid}, 32'd0);
         chk("async_req", {31'd0, imem_req}, 32'd0);
         chk("async_halt", {31'd0, halt}, 32'd0);
         chk("async_ps", {30'd0, ps}, 32'd0);
         chk("async_count", instr_count, 32'd0);
         sb.delete();
         model_count = 0;
         @(negedge clk);
         @(negedge clk);
         rst = 1'b1;
         #1 chk("rel_idle_req", {31'd0, imem_req}, 32'd0);
         @(negedge clk);
         chk("rel_fetch_req", {31'd0, imem_req}, 32'd1);
      end

      for (int i = 0; i < 20; i++) begin
         int dd;
         dd = $urandom_range(0, 2);
         do_instr(rand_instr(), 4'($urandom), $urandom_range(0, 2), dd, dd > 0);
      end

      // HALT: must freeze with ps=00 and leave the counter untouched.
      wait_req(ok);
      if (ok) begin
         imem_rdata = 32'hF000_0000;
         imem_ack   = 1'b1;
         @(negedge clk);
         imem_ack = 1'b0;
         @(negedge clk);
         for (int i = 0; i < 25; i++) begin
            chk("halt", {31'd0, halt}, 32'd1);
            chk("halt_ps", {30'd0, ps}, 32'd0);
            chk("halt_count", instr_count, model_count);
            chk("halt_req", {31'd0, imem_req}, 32'd0);
            @(negedge clk);
         end
      end
      chk("sb_drained", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
